// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared constants and state encoding for the LED scheduler
package led_sched_pkg;

  localparam int LED_W = 8;
  localparam int SLICE_DEF = 25_000_000;
  localparam logic [LED_W-1:0] IDLE_PAT_DEF = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_scheduler_if.sv
// rtl/led_scheduler_if.sv - request/pattern inputs and LED/grant outputs of the scheduler
interface led_scheduler_if
  import led_sched_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]       i_req;
  logic [LED_W*NREQ-1:0] i_pat;
  logic [LED_W-1:0]      o_led;
  logic [NREQ-1:0]       o_grant;
  logic                  o_busy;
  logic                  o_slice_end;

  modport master (
    output i_req, i_pat,
    input  o_led, o_grant, o_busy, o_slice_end
  );

  modport slave (
    input  i_req, i_pat,
    output o_led, o_grant, o_busy, o_slice_end
  );

endinterface

// File: rtl/led_scheduler_rr_pick.sv
// rtl/led_scheduler_rr_pick.sv - combinational round-robin pick: first set bit at or after start
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest pending bit wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(start) + k) % N);
      if (req[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// rtl/led_scheduler.sv - time-sliced round-robin owner of a shared 8-bit LED bank
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int               NREQ     = 4,
  parameter int               SLICE    = SLICE_DEF,
  parameter logic [LED_W-1:0] IDLE_PAT = IDLE_PAT_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  led_scheduler_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SLICE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLICE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             slice_end_q, slice_end_d;

  logic [NREQ-1:0]  pick_req;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             expire;
  logic             owner_drop;

  // While owning, ptr already sits at owner+1, so one picker serves both states.
  assign pick_req   = (state_q == ST_OWN) ? (bus.i_req & ~grant_q) : bus.i_req;
  assign expire     = (cnt_q == CNT_LAST);
  assign owner_drop = ~bus.i_req[owner_q];

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (pick_req),
    .start (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
    return (k == IDX_LAST) ? '0 : IW'(k + 1'b1);
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    slice_end_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          owner_d = pick_idx;
          ptr_d   = next_idx(pick_idx);
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        slice_end_d = expire;
        if ((owner_drop || expire) && pick_valid) begin
          owner_d = pick_idx;
          ptr_d   = next_idx(pick_idx);
          cnt_d   = '0;
        end else if (owner_drop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_OWN);
    grant_d = busy_d ? ({{(NREQ - 1){1'b0}}, 1'b1} << owner_d) : '0;
    led_d   = busy_d ? bus.i_pat[owner_d * LED_W +: LED_W] : IDLE_PAT;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      led_q       <= IDLE_PAT;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      slice_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      slice_end_q <= slice_end_d;
    end
  end

  assign bus.o_led       = led_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_slice_end = slice_end_q;

endmodule
